// File: rtl/ntt_sched_pkg.sv
// Shared types and constants for the forward-NTT butterfly scheduler.
package ntt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  localparam logic MODE_DIL = 1'b0;
  localparam logic MODE_KYB = 1'b1;

  // Write-back must trail issue by the RAM read plus the butterfly pipeline.
  function automatic int wb_lat(input int mem_lat, input int bf_lat);
    return mem_lat + bf_lat;
  endfunction

endpackage

// File: rtl/ntt_wb_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from issue to write-back.
// any_vld_o reports entries that are still in flight after the current clock edge.
module ntt_wb_delay
  import ntt_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         any_vld_o
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = sr_q[DEPTH-1];

  // The output stage is excluded so the next layer can issue right after the last write-back.
  always_comb begin
    any_vld_o = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) any_vld_o = any_vld_o | sr_q[i][W-1];
  end

endmodule

// File: rtl/ntt_bf_scheduler.sv
// In-place forward NTT sequencer: one butterfly pair per cycle, layer drain, delayed write-back.
// Optional NTT_SCHED_STALL_EN adds a stall input that freezes issue while in ISSUE.
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | issuing one pair per cycle for the current layer
// DRAIN | waiting for in-flight write-backs of the layer to retire
// DONE  | one-cycle done pulse
module ntt_bf_scheduler
  import ntt_sched_pkg::*;
#(
  parameter int N       = 256,
  parameter int LOG_N   = 8,
  parameter int MEM_LAT = 1,
  parameter int BF_LAT  = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
`ifdef NTT_SCHED_STALL_EN
  input  logic             stall_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [LOG_N-1:0] rd_addr_a_o,
  output logic [LOG_N-1:0] rd_addr_b_o,
  output logic [LOG_N-1:0] tw_idx_o,
  output logic             wr_en_o,
  output logic [LOG_N-1:0] wr_addr_a_o,
  output logic [LOG_N-1:0] wr_addr_b_o
);

  localparam int WB_LAT = wb_lat(MEM_LAT, BF_LAT);
  localparam int WB_W   = 2 * LOG_N + 1;
  localparam logic [LOG_N-1:0] ONE     = LOG_N'(1);
  localparam logic [LOG_N-1:0] LEN0    = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] HALF_M1 = LOG_N'(N / 2 - 1);

  sched_state_e     state_q, state_d;
  logic             mode_q, mode_d;
  logic [LOG_N-1:0] len_q, len_d;
  logic [LOG_N-1:0] j_q, j_d;
  logic [LOG_N-1:0] a_q, a_d;
  logic [LOG_N-1:0] b_q, b_d;
  logic [LOG_N-1:0] k_q, k_d;
  logic [LOG_N-1:0] cnt_q, cnt_d;
  logic             rd_en_q, busy_q, done_q;
  logic             stall_w;
  logic             pend_vld;
  logic [LOG_N-1:0] min_len;
  logic [WB_W-1:0]  wb_out;

`ifdef NTT_SCHED_STALL_EN
  assign stall_w = stall_i;
`else
  assign stall_w = 1'b0;
`endif

  assign min_len = (mode_q == MODE_KYB) ? LOG_N'(2) : ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_DIL;
      len_q   <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      rd_en_q <= (state_d == ISSUE);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    j_d     = j_q;
    a_d     = a_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ISSUE;
          mode_d  = mode_i;
          len_d   = LEN0;
          j_d     = '0;
          a_d     = '0;
          k_d     = ONE;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (!stall_w) begin
          cnt_d = cnt_q + ONE;
          if (j_q == len_q - ONE) begin
            // Skip over the upper half of the group to reach the next group's base.
            j_d = '0;
            a_d = a_q + len_q + ONE;
            k_d = k_q + ONE;
          end else begin
            j_d = j_q + ONE;
            a_d = a_q + ONE;
          end
          if (cnt_q == HALF_M1) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (!pend_vld) begin
          if (len_q == min_len) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            len_d   = len_q >> 1;
            j_d     = '0;
            a_d     = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    b_d = a_d + len_d;
  end

  assign rd_en_o     = rd_en_q & ~stall_w;
  assign rd_addr_a_o = a_q;
  assign rd_addr_b_o = b_q;
  assign tw_idx_o    = k_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  ntt_wb_delay #(
    .DEPTH(WB_LAT),
    .W    (WB_W)
  ) u_wb_delay (
    .clk      (clk),
    .rst      (rst),
    .d_i      ({rd_en_o, a_q, b_q}),
    .q_o      (wb_out),
    .any_vld_o(pend_vld)
  );

  assign wr_en_o     = wb_out[WB_W-1];
  assign wr_addr_a_o = wb_out[2*LOG_N-1:LOG_N];
  assign wr_addr_b_o = wb_out[LOG_N-1:0];

endmodule

// File: tb/tb_ntt_bf_scheduler.sv
// Directed bench for ntt_bf_scheduler: Kyber/Dilithium sequences, busy-start, back-to-back, reset, stall.
module tb_ntt_bf_scheduler;
  localparam int N     = 256;
  localparam int LOG_N = 8;
  localparam int WB    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic             mode_i;
`ifdef NTT_SCHED_STALL_EN
  logic             stall_i;
`endif
  logic             busy_o, done_o, rd_en_o, wr_en_o;
  logic [LOG_N-1:0] rd_addr_a_o, rd_addr_b_o, tw_idx_o, wr_addr_a_o, wr_addr_b_o;

  always #5 clk = ~clk;

  ntt_bf_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .mode_i     (mode_i),
`ifdef NTT_SCHED_STALL_EN
    .stall_i    (stall_i),
`endif
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rd_en_o    (rd_en_o),
    .rd_addr_a_o(rd_addr_a_o),
    .rd_addr_b_o(rd_addr_b_o),
    .tw_idx_o   (tw_idx_o),
    .wr_en_o    (wr_en_o),
    .wr_addr_a_o(wr_addr_a_o),
    .wr_addr_b_o(wr_addr_b_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int exp_a[1024], exp_b[1024], exp_k[1024];
  int exp_n;

  // Textbook Cooley-Tukey loop order: layer, group, butterfly within group.
  function automatic void build_model(input logic md);
    int len, k, idx;
    idx = 0;
    k   = 1;
    for (len = N / 2; len >= (md ? 2 : 1); len = len / 2) begin
      for (int st = 0; st < N; st += 2 * len) begin
        for (int j = st; j < st + len; j++) begin
          exp_a[idx] = j;
          exp_b[idx] = j + len;
          exp_k[idx] = k;
          idx++;
        end
        k++;
      end
    end
    exp_n = idx;
  endfunction

  typedef struct {int t; int a; int b;} wb_t;
  wb_t wq[$];
  bit  pend[N];

  int rd_n, wr_n, done_n, done_cyc, last_wr, first_rd, busy_first, busy_last, late_rd, post_rst_act;
  int last_a, last_b, last_k;
  int snap_a[4], snap_b[4], snap_k[4];

  task automatic run_xform(input logic md, input int st2, input int st2_len,
                           input int rst_at, input int stall_n, input int budget);
    int  end_n, s;
    bit  in_x;
    wb_t e;
    build_model(md);
    rd_n = 0; wr_n = 0; done_n = 0; done_cyc = -1; last_wr = -1; first_rd = -1;
    busy_first = -1; busy_last = -1; late_rd = -1; post_rst_act = 0;
    last_a = -1; last_b = -1; last_k = -1;
    for (int i = 0; i < 4; i++) begin snap_a[i] = -1; snap_b[i] = -1; snap_k[i] = -1; end
    wq.delete();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    end_n = budget;
    for (int n = 0; n <= end_n; n++) begin
      @(negedge clk);
      start_i = (n == 0) || (st2 >= 0 && n >= st2 && n < st2 + st2_len);
      mode_i  = (n == 0) ? md : ~md;
      rst     = (rst_at >= 0 && n == rst_at);
`ifdef NTT_SCHED_STALL_EN
      stall_i = (n >= 20 && n < 20 + stall_n);
`endif
      #1;
      if (rst_at >= 0 && n == rst_at + 1) begin
        chk("rst_busy", busy_o, 0);
        chk("rst_rd_en", rd_en_o, 0);
        chk("rst_wr_en", wr_en_o, 0);
        chk("rst_rd_addr", {rd_addr_a_o, rd_addr_b_o}, 0);
        chk("rst_tw", tw_idx_o, 0);
        chk("rst_wr_addr", {wr_addr_a_o, wr_addr_b_o}, 0);
      end
      if (rst_at >= 0 && n > rst_at) begin
        if (rd_en_o || wr_en_o || busy_o || done_o) post_rst_act++;
      end else begin
        if (done_o) begin
          done_n++;
          if (done_cyc < 0) begin
            done_cyc = n;
            end_n    = n + 4;
          end
        end
        in_x = (done_cyc < 0) || (n <= done_cyc);
        if (busy_o && in_x) begin
          if (busy_first < 0) busy_first = n;
          busy_last = n;
        end
        if (rd_en_o) begin
          if (!in_x) begin
            if (late_rd < 0) late_rd = n;
          end else begin
            if (rd_n < exp_n) begin
              chk("rd_a", rd_addr_a_o, exp_a[rd_n]);
              chk("rd_b", rd_addr_b_o, exp_b[rd_n]);
              chk("tw", tw_idx_o, exp_k[rd_n]);
            end else begin
              chk("rd_extra", rd_n + 1, exp_n);
            end
            chk("raw_hazard", {31'd0, pend[rd_addr_a_o] | pend[rd_addr_b_o]}, 0);
            pend[rd_addr_a_o] = 1'b1;
            pend[rd_addr_b_o] = 1'b1;
            wq.push_back('{n + WB, int'(rd_addr_a_o), int'(rd_addr_b_o)});
            rd_n++;
            if (first_rd < 0) first_rd = n;
            last_a = rd_addr_a_o; last_b = rd_addr_b_o; last_k = tw_idx_o;
            s = (n == 1) ? 0 : (n == 128) ? 1 : (n == 137) ? 2 : (n == 953) ? 3 : -1;
            if (s >= 0) begin
              snap_a[s] = rd_addr_a_o; snap_b[s] = rd_addr_b_o; snap_k[s] = tw_idx_o;
            end
          end
        end
        if (wr_en_o) begin
          wr_n++;
          last_wr = n;
          if (wq.size() == 0) begin
            chk("wr_spurious", 1, 0);
          end else begin
            e = wq.pop_front();
            chk("wr_lat", n, e.t);
            chk("wr_a", wr_addr_a_o, e.a);
            chk("wr_b", wr_addr_b_o, e.b);
            pend[e.a] = 1'b0;
            pend[e.b] = 1'b0;
          end
        end
      end
    end
    start_i = 1'b0;
    rst     = 1'b0;
`ifdef NTT_SCHED_STALL_EN
    stall_i = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_kyber_nominal(input string pfx);
    chk({pfx, "_done_cyc"}, done_cyc, 953);
    chk({pfx, "_done_n"}, done_n, 1);
    chk({pfx, "_last_wr"}, last_wr, 952);
    chk({pfx, "_rd_n"}, rd_n, 896);
    chk({pfx, "_wr_n"}, wr_n, 896);
    chk({pfx, "_first_rd"}, first_rd, 1);
    chk({pfx, "_c1"}, {snap_a[0][7:0], snap_b[0][7:0], snap_k[0][7:0]}, {8'd0, 8'd128, 8'd1});
    chk({pfx, "_c128"}, {snap_a[1][7:0], snap_b[1][7:0], snap_k[1][7:0]}, {8'd127, 8'd255, 8'd1});
    chk({pfx, "_c137"}, {snap_a[2][7:0], snap_b[2][7:0], snap_k[2][7:0]}, {8'd0, 8'd64, 8'd2});
    chk({pfx, "_last_issue"}, {last_a[7:0], last_b[7:0], last_k[7:0]}, {8'd253, 8'd255, 8'd127});
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    mode_i  = 1'b0;
`ifdef NTT_SCHED_STALL_EN
    stall_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_rd_en", rd_en_o, 0);
    chk("reset_wr_en", wr_en_o, 0);
    chk("reset_rd_addr", {rd_addr_a_o, rd_addr_b_o}, 0);
    chk("reset_tw", tw_idx_o, 0);
    chk("reset_wr_addr", {wr_addr_a_o, wr_addr_b_o}, 0);
    #1 rst = 1'b0;

    run_xform(1'b1, -1, 0, -1, 0, 1200);
    chk_kyber_nominal("kyb");
    chk("kyb_busy_first", busy_first, 1);
    chk("kyb_busy_last", busy_last, 953);
    chk("kyb_wq_empty", wq.size(), 0);

    do_reset();
    run_xform(1'b1, 300, 1, -1, 0, 1200);
    chk("busy_start_done", done_cyc, 953);
    chk("busy_start_rd_n", rd_n, 896);
    chk("busy_start_last_k", last_k, 127);

    do_reset();
    run_xform(1'b0, 1089, 2, -1, 0, 1300);
    chk("dil_done_cyc", done_cyc, 1089);
    chk("dil_last_wr", last_wr, 1088);
    chk("dil_rd_n", rd_n, 1024);
    chk("dil_wr_n", wr_n, 1024);
    chk("dil_c953", {snap_a[3][7:0], snap_b[3][7:0], snap_k[3][7:0]}, {8'd0, 8'd1, 8'd128});
    chk("dil_last_issue", {last_a[7:0], last_b[7:0], last_k[7:0]}, {8'd254, 8'd255, 8'd255});
    chk("dil_busy_last", busy_last, 1089);
    chk("b2b_restart_rd", late_rd, 1091);

    do_reset();
    run_xform(1'b1, -1, 0, 500, 0, 600);
    chk("rst_mid_activity", post_rst_act, 0);
    run_xform(1'b1, -1, 0, -1, 0, 1200);
    chk_kyber_nominal("after_rst");

`ifdef NTT_SCHED_STALL_EN
    do_reset();
    run_xform(1'b1, -1, 0, -1, 10, 1200);
    chk("stall_done_cyc", done_cyc, 963);
    chk("stall_last_wr", last_wr, 962);
    chk("stall_rd_n", rd_n, 896);
    chk("stall_wr_n", wr_n, 896);
    chk("stall_last_issue", {last_a[7:0], last_b[7:0], last_k[7:0]}, {8'd253, 8'd255, 8'd127});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_bf_scheduler.md
# ntt_bf_scheduler

Sequencer for the in-place forward NTT shared by the Kyber and Dilithium paths. It walks every layer, issues one butterfly pair per cycle to the coefficient RAM and fixed-latency butterfly pipeline, and supplies the twiddle index. It also delays the pair addresses to align write-back with the butterfly output, and drains the pipeline between layers to remove read-after-write hazards. The block sits between the top-level control FSM and the coefficient RAM / butterfly datapath.

## Interface
- N, 256, polynomial length (power of two)
- LOG_N, 8, log2(N); width of addresses and twiddle index
- MEM_LAT, 1, RAM read latency in cycles
- BF_LAT, 7, butterfly pipeline latency in cycles
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one transform; honoured in IDLE only
- mode  in  1  0 = Dilithium (len N/2..1), 1 = Kyber (len N/2..2); sampled with start
- busy  out  1  transform in progress
- done  out  1  one-cycle pulse after the final write-back
- rd_en  out  1  butterfly issue / RAM read strobe
- rd_addr_a, rd_addr_b  out  LOG_N  pair (j, j+len)
- tw_idx  out  LOG_N  twiddle index k, valid with rd_en
- wr_en  out  1  write-back strobe
- wr_addr_a, wr_addr_b  out  LOG_N  delayed pair addresses
- stall  in  1  present only with NTT_SCHED_STALL_EN

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + start -> ISSUE. Latch mode, set len=N/2, grp=0, j=0, k=1.
- ISSUE: issue one pair per cycle with rd_en=1, rd_addr_a=grp+j, rd_addr_b=grp+j+len, tw_idx=k.
  - j increments. When j=len-1: j<=0, grp<=grp+2·len, k<=k+1.
  - The last pair of a layer (grp+j = N-len-1+... i.e. the N/2-th issue) -> DRAIN.
- DRAIN: no issue. Wait until the write-back pipe holds no valid entry, then:
  - if len equals the mode's minimum (2 Kyber, 1 Dilithium) -> DONE;
  - otherwise len<=len>>1, grp<=0, j<=0 -> ISSUE. k continues and is not reset.
- DONE: done=1 for one cycle -> IDLE.
- Write-back pipe: {valid, addr_a, addr_b} delayed by WB_LAT = MEM_LAT+BF_LAT cycles. Its output drives wr_en/wr_addr_*.
- Each layer issues exactly N/2 pairs. k runs 1..N/2-1 for Kyber and 1..N-1 for Dilithium.
- start while busy is ignored. mode changes while busy have no effect.
- rst at any time: FSM to IDLE, counters and pipe cleared, in-flight writes discarded.

## Timing
- Reset values: busy, done, rd_en, wr_en = 0; all addresses and tw_idx = 0.
- Outputs are registered.
- start sampled at edge 0. First rd_en in cycle 1. busy is high from cycle 1 through the done cycle.
- wr_en for an issue in cycle t appears in cycle t+WB_LAT.
- Next layer's first issue is the cycle after the previous layer's last wr_en.
- Per-layer period: N/2+WB_LAT = 136 cycles at defaults.
- Defaults: Kyber last wr_en in cycle 952, done in cycle 953. Dilithium last wr_en in cycle 1088, done in cycle 1089.
- Back-to-back: start in the done cycle is ignored. start in the following IDLE cycle is accepted.

## Configuration
- NTT_SCHED_STALL_EN defined:
  - stall port exists.
  - stall=1 in ISSUE suppresses rd_en and freezes j/grp/len/k. A bubble enters the write-back pipe.
  - In-flight entries keep advancing.
  - stall has no effect in IDLE, DRAIN or DONE.
  - Each stalled cycle extends done by one cycle.
- Undefined: no stall port; one issue every ISSUE cycle.

## Structure
- Package ntt_sched_pkg holds:
  - the state enum;
  - mode encodings MODE_DIL=0 and MODE_KYB=1;
  - the WB_LAT derivation.
- Sub-module ntt_wb_delay: parameterised-depth, parameterised-width shift register with asynchronous reset to zero. It carries {valid, addr_a, addr_b} and exposes an any-valid flag for DRAIN.

## Test plan
- Kyber start at cycle 0 -> cycle 1: rd (0,128) tw 1; cycle 128: (127,255) tw 1; cycle 137: (0,64) tw 2; last issue (253,255) tw 127; done in cycle 953.
- Dilithium start -> final layer issues (0,1) tw 128 … (254,255) tw 255; done in cycle 1089; exactly 1024 rd_en and 1024 wr_en.
- Every issue -> matching wr_en with identical addresses exactly 8 cycles later. No rd of an address in layer L+1 before its wr in layer L.
- start pulsed in cycle 300 while busy -> ignored; done still in cycle 953 (Kyber).
- rst asserted in cycle 500 mid-layer -> all outputs 0 next cycle, no further wr_en; a subsequent start reproduces scenario 1 timing.
- With NTT_SCHED_STALL_EN: 10 stall cycles in layer 0 -> identical address/tw_idx sequence, done in cycle 963 (Kyber).
